// File: rtl/qspi_pkg.sv
// Shared constants for the QSPI controller datapath.
// Word width and default FIFO depths used by the RX and TX buffers.
package qspi_pkg;

    localparam int QSPI_WORD_W       = 32;
    localparam int QSPI_RX_DEPTH_DEF = 16;
    localparam int QSPI_TX_DEPTH_DEF = 16;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/qspi_rx_fifo_if.sv
// Write/read handshake bundle between qspi_fsm, the RX FIFO and the host.
// master = producer/consumer side, slave = the FIFO itself.
interface qspi_rx_fifo_if
    import qspi_pkg::*;
#(
    parameter int DATA_W = QSPI_WORD_W
);

    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;

    modport master (
        output wr_data,
        output wr_en,
        output rd_en,
        input  full,
        input  rd_data,
        input  empty
    );

    modport slave (
        input  wr_data,
        input  wr_en,
        input  rd_en,
        output full,
        output rd_data,
        output empty
    );

endinterface

// File: rtl/qspi_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module qspi_fifo_mem
    import qspi_pkg::*;
#(
    parameter  int DATA_W = QSPI_WORD_W,
    parameter  int DEPTH  = QSPI_RX_DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/qspi_rx_fifo.sv
// Receive word FIFO behind qspi_fsm: FWFT read, fill level,
// threshold indication and sticky overflow/underflow flags.
module qspi_rx_fifo
    import qspi_pkg::*;
#(
    parameter  int DATA_W = QSPI_WORD_W,
    parameter  int DEPTH  = QSPI_RX_DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    qspi_rx_fifo_if.slave     bus,
    output logic [AW:0]       level,
    input  logic [AW:0]       thresh,
    output logic              thresh_hit,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("qspi_rx_fifo: DEPTH must be a power of two >= 2");
    end

    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level_q;
    logic              ovf_q;
    logic              unf_q;

    logic              empty_c;
    logic              full_c;
    logic              push;
    logic              pop;
    logic              ovf_ev;
    logic              unf_ev;
    logic              mem_we;
    logic [DATA_W-1:0] head;

    // A push into a full FIFO is legal only when a pop frees the slot.
    always_comb begin
        empty_c = (level_q == '0);
        full_c  = (level_q == LVL_FULL);
        pop     = bus.rd_en && !empty_c;
        push    = bus.wr_en && (!full_c || pop);
        ovf_ev  = bus.wr_en && !push;
        unf_ev  = bus.rd_en && empty_c;
        mem_we  = push && !reset && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= ovf_q && !clr_err;
            unf_q   <= unf_q && !clr_err;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            // A fresh error event wins over a concurrent clear.
            ovf_q <= ovf_ev || (ovf_q && !clr_err);
            unf_q <= unf_ev || (unf_q && !clr_err);
        end
    end

    qspi_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign bus.full    = full_c;
    assign bus.empty   = empty_c;
    assign bus.rd_data = empty_c ? '0 : head;

    assign level      = level_q;
    assign thresh_hit = (thresh != '0) && (level_q >= thresh);
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: doc/qspi_rx_fifo.md
Name: qspi_rx_fifo

Overview:
- Receive-side word buffer directly downstream of qspi_fsm.
- Its write port attaches to qspi_fsm's rx_data_fifo / rx_wen / rx_full.
- Its read port is popped by the host register interface.
- Provides first-word-fall-through reads, a fill level, a threshold indication and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 32, word width; must match the qspi_fsm RX word width.
- DEPTH, 16, number of entries; must be a power of two and ≥ 2.
- AW, $clog2(DEPTH), derived local parameter; pointer width (not overridable).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous single-cycle clear of contents.
- wr_data  in  DATA_W  word from qspi_fsm rx_data_fifo.
- wr_en  in  1  push strobe from qspi_fsm rx_wen.
- full  out  1  to qspi_fsm rx_full.
- rd_en  in  1  pop strobe from the host side.
- rd_data  out  DATA_W  head word; valid whenever empty=0.
- empty  out  1  FIFO holds no words.
- level  out  AW+1  current word count, 0..DEPTH.
- thresh  in  AW+1  threshold level; 0 disables the indication.
- thresh_hit  out  1  high when thresh≠0 and level≥thresh.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop occurred while empty.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (reset=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, level=0, overflow=0, underflow=0.
  - Outputs: empty=1, full=0, thresh_hit=0.
  - rd_data=0 while empty; storage array contents are not reset.
- Storage and pointers:
  - Register array, DEPTH×DATA_W.
  - rd_data is a combinational read of mem[rd_ptr] (FWFT); it is forced to 0 when empty.
  - Pointers are AW bits wide and wrap modulo DEPTH with no extra logic (DEPTH-1 → 0).
  - level is an explicit AW+1-bit counter. empty=(level==0) and full=(level==DEPTH), both decoded combinationally from registered level.
- Push: wr_en=1 and (full=0, or rd_en=1 with level≠0) → mem[wr_ptr]<=wr_data and wr_ptr++.
- Pop: rd_en=1 and empty=0 → rd_ptr++. rd_data shows the next word in the following cycle.
- Level update, same cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together.
- Full with wr_en and rd_en together: both occur; level stays DEPTH; no overflow.
- Full with wr_en only: word dropped, no state change except overflow<=1.
- Empty with rd_en, with or without wr_en:
  - The pop is ignored; rd_ptr and rd_data are unchanged; underflow<=1.
  - A concurrent wr_en still pushes, so level becomes 1.
  - There is no write-to-read bypass; the new word appears at rd_data one cycle later.
- Flush priority:
  - Ordering is reset > flush > wr_en/rd_en.
  - Flush zeroes wr_ptr, rd_ptr and level.
  - Concurrent wr_en/rd_en are discarded and raise no flags.
  - Sticky flags are NOT cleared by flush.
- Error flag clearing: clr_err=1 clears overflow and underflow. If a new error event occurs in the same cycle, the set wins and the flag stays 1.
- Latency: push to visible on rd_data/empty is 1 cycle; pop to next head is 1 cycle.
- thresh_hit: registered-level based, combinational compare. thresh>DEPTH means it never asserts.
- Mid-operation reset: takes effect at the next edge regardless of other inputs; all words are lost.
- full path: full is a registered-derived signal with no combinational path from wr_en/rd_en. qspi_fsm sees backpressure one cycle after the last accepted push.

Decomposition:
- qspi_pkg holds:
  - QSPI_WORD_W=32.
  - QSPI_RX_DEPTH_DEF=16.
  - QSPI_TX_DEPTH_DEF=16 (shared with a future qspi_tx_fifo).
- One natural sub-module: qspi_fifo_mem, a DEPTH×DATA_W register array with one write port and one async read port. The same sub-module is reused by qspi_tx_fifo.
- Pointer, level and flag logic stays in qspi_rx_fifo.

Test Plan:
- Fill/drain: after reset, push 0x1000_0000..0x1000_000F (16 words) → full=1, level=16. Push 0xDEAD_BEEF → overflow=1, level=16. Pop 16 words → rd_data reads back 0x1000_0000..0x1000_000F in order, then empty=1.
- Wrap-around: push 10, pop 10, push 12 words 0xA0..0xAB → level=12, pointers wrapped, pops return 0xA0..0xAB in order.
- Simultaneous push/pop:
  - At full: push 0x55 + pop together → level stays 16, overflow stays 0, 0x55 becomes the last word read.
  - At empty: push 0x77 + pop together → underflow=1, level=1, rd_data=0x77 next cycle.
- Flush: with level=5, assert flush together with wr_en=1 (0x99) → level=0, empty=1, no flags set; the next push of 0x42 reads back as 0x42.
- Threshold/flags:
  - thresh=4: thresh_hit rises on the cycle after the 4th push and falls after the pop that takes level to 3.
  - thresh=0: thresh_hit stays 0.
  - clr_err together with an overflowing push: overflow remains 1; clr_err alone then clears it.
- FSM integration: connect to qspi_fsm with clk_div=0, dir=1 (read), len_bytes=80 (20 words), host not popping → full asserts, rx_wen stalls, no overflow; popping resumes transfer; all 20 words are delivered in order.
